// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver: op codes, ALU control words and FSM states.
// Control words are ordered {zx, nx, zy, ny, f, no} from MSB to LSB.
package alu_pkg;

   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctl_t;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      RESP
   } state_e;

   localparam logic [4:0] OP_ZERO    = 5'd0;
   localparam logic [4:0] OP_ONE     = 5'd1;
   localparam logic [4:0] OP_NEG_ONE = 5'd2;
   localparam logic [4:0] OP_X       = 5'd3;
   localparam logic [4:0] OP_Y       = 5'd4;
   localparam logic [4:0] OP_NOT_X   = 5'd5;
   localparam logic [4:0] OP_NOT_Y   = 5'd6;
   localparam logic [4:0] OP_NEG_X   = 5'd7;
   localparam logic [4:0] OP_NEG_Y   = 5'd8;
   localparam logic [4:0] OP_X_INC   = 5'd9;
   localparam logic [4:0] OP_Y_INC   = 5'd10;
   localparam logic [4:0] OP_X_DEC   = 5'd11;
   localparam logic [4:0] OP_Y_DEC   = 5'd12;
   localparam logic [4:0] OP_ADD     = 5'd13;
   localparam logic [4:0] OP_X_SUB_Y = 5'd14;
   localparam logic [4:0] OP_Y_SUB_X = 5'd15;
   localparam logic [4:0] OP_AND     = 5'd16;
   localparam logic [4:0] OP_OR      = 5'd17;

   localparam alu_ctl_t CTL_ZERO    = 6'b101010;
   localparam alu_ctl_t CTL_ONE     = 6'b111111;
   localparam alu_ctl_t CTL_NEG_ONE = 6'b111010;
   localparam alu_ctl_t CTL_X       = 6'b001100;
   localparam alu_ctl_t CTL_Y       = 6'b110000;
   localparam alu_ctl_t CTL_NOT_X   = 6'b001101;
   localparam alu_ctl_t CTL_NOT_Y   = 6'b110001;
   localparam alu_ctl_t CTL_NEG_X   = 6'b001111;
   localparam alu_ctl_t CTL_NEG_Y   = 6'b110011;
   localparam alu_ctl_t CTL_X_INC   = 6'b011111;
   localparam alu_ctl_t CTL_Y_INC   = 6'b110111;
   localparam alu_ctl_t CTL_X_DEC   = 6'b001110;
   localparam alu_ctl_t CTL_Y_DEC   = 6'b110010;
   localparam alu_ctl_t CTL_ADD     = 6'b000010;
   localparam alu_ctl_t CTL_X_SUB_Y = 6'b010011;
   localparam alu_ctl_t CTL_Y_SUB_X = 6'b000111;
   localparam alu_ctl_t CTL_AND     = 6'b000000;
   localparam alu_ctl_t CTL_OR      = 6'b010101;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op-code decoder: maps a 5-bit op code onto the six ALU control bits.
// Codes above OP_OR are flagged illegal and decode to an all-zero control word.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [4:0] op_i,
   output alu_ctl_t   ctl_o,
   output logic       legal_o
);

   always_comb begin
      ctl_o   = '0;
      legal_o = 1'b1;
      case (op_i)
         OP_ZERO:    ctl_o = CTL_ZERO;
         OP_ONE:     ctl_o = CTL_ONE;
         OP_NEG_ONE: ctl_o = CTL_NEG_ONE;
         OP_X:       ctl_o = CTL_X;
         OP_Y:       ctl_o = CTL_Y;
         OP_NOT_X:   ctl_o = CTL_NOT_X;
         OP_NOT_Y:   ctl_o = CTL_NOT_Y;
         OP_NEG_X:   ctl_o = CTL_NEG_X;
         OP_NEG_Y:   ctl_o = CTL_NEG_Y;
         OP_X_INC:   ctl_o = CTL_X_INC;
         OP_Y_INC:   ctl_o = CTL_Y_INC;
         OP_X_DEC:   ctl_o = CTL_X_DEC;
         OP_Y_DEC:   ctl_o = CTL_Y_DEC;
         OP_ADD:     ctl_o = CTL_ADD;
         OP_X_SUB_Y: ctl_o = CTL_X_SUB_Y;
         OP_Y_SUB_X: ctl_o = CTL_Y_SUB_X;
         OP_AND:     ctl_o = CTL_AND;
         OP_OR:      ctl_o = CTL_OR;
         default:    legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_driver.sv
// Sequential initiator for the zx/nx/zy/ny/f/no ALU: takes one command, holds the ALU
// drive for SETTLE_CYCLES cycles, samples the result and offers it as a response.
module alu_driver
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [4:0] cmd_op_i,
   input  logic [3:0] cmd_x_i,
   input  logic [3:0] cmd_y_i,
   output logic       alu_zx_o,
   output logic       alu_nx_o,
   output logic       alu_zy_o,
   output logic       alu_ny_o,
   output logic       alu_f_o,
   output logic       alu_no_o,
   output logic [3:0] alu_x_o,
   output logic [3:0] alu_y_o,
   input  logic [3:0] alu_o_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [3:0] rsp_data_o,
   output logic       rsp_zr_o,
   output logic       rsp_ng_o,
   output logic       rsp_err_o
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_e     state_q;
   logic       cmd_ready_q;
   logic       rsp_valid_q;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   alu_ctl_t   ctl_q;
   logic [3:0] x_q;
   logic [3:0] y_q;
   logic [3:0] rsp_data_q;
   logic       rsp_zr_q;
   logic       rsp_ng_q;
   logic       rsp_err_q;

   alu_ctl_t   dec_ctl;
   logic       dec_legal;

   alu_op_decode u_decode (
      .op_i    (cmd_op_i),
      .ctl_o   (dec_ctl),
      .legal_o (dec_legal)
   );

   assign cnt_d = cnt_q + 4'd1;

   // The ALU drive registers are only written on a legal accept, so they persist
   // through IDLE and RESP and across illegal commands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         cnt_q       <= '0;
         ctl_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         rsp_data_q  <= '0;
         rsp_zr_q    <= 1'b0;
         rsp_ng_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid_i && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  if (dec_legal) begin
                     ctl_q   <= dec_ctl;
                     x_q     <= cmd_x_i;
                     y_q     <= cmd_y_i;
                     cnt_q   <= '0;
                     state_q <= DRIVE;
                  end else begin
                     rsp_data_q  <= '0;
                     rsp_zr_q    <= 1'b0;
                     rsp_ng_q    <= 1'b0;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end
               end
            end
            DRIVE: begin
               if (cnt_q == SETTLE_LAST) begin
                  rsp_data_q  <= alu_o_i;
                  rsp_zr_q    <= (alu_o_i == 4'd0);
                  rsp_ng_q    <= alu_o_i[3];
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign alu_zx_o    = ctl_q.zx;
   assign alu_nx_o    = ctl_q.nx;
   assign alu_zy_o    = ctl_q.zy;
   assign alu_ny_o    = ctl_q.ny;
   assign alu_f_o     = ctl_q.f;
   assign alu_no_o    = ctl_q.no;
   assign alu_x_o     = x_q;
   assign alu_y_o     = y_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_zr_o    = rsp_zr_q;
   assign rsp_ng_o    = rsp_ng_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: two drivers (settle 1 and 3) each paired with a behavioural ALU,
// an operation-level reference model, and directed vectors with literal expectations.
module tb_alu_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Settle-1 driver
   logic       rst_n;
   logic       cmdValid, cmdReady, rspValid, rspReady;
   logic [4:0] cmdOp;
   logic [3:0] cmdX, cmdY, aluX, aluY, aluO, rspData;
   logic       zx, nx, zy, ny, fSel, no;
   logic       rspZr, rspNg, rspErr;
   logic [5:0] ctl;

   // Settle-3 driver
   logic       rst3_n;
   logic       cmdValid3, cmdReady3, rspValid3, rspReady3;
   logic [4:0] cmdOp3;
   logic [3:0] cmdX3, cmdY3, aluX3, aluY3, aluO3, rspData3;
   logic       zx3, nx3, zy3, ny3, fSel3, no3;
   logic       rspZr3, rspNg3, rspErr3;
   logic [5:0] ctl3;

   int passCount = 0;
   int totalCount = 0;

   logic [5:0] ctlTable [18] = '{
      6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
      6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
      6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

   // The ALU itself, evaluated from its control bits.
   function automatic logic [3:0] aluEval(input logic [5:0] c, input logic [3:0] x, input logic [3:0] y);
      logic [3:0] a, b, o;
      a = c[5] ? 4'd0 : x;
      if (c[4]) a = ~a;
      b = c[3] ? 4'd0 : y;
      if (c[2]) b = ~b;
      o = c[1] ? (a + b) : (a & b);
      if (c[0]) o = ~o;
      return o;
   endfunction

   // What each operation means arithmetically, independent of the control encoding.
   function automatic logic [3:0] opResult(input int op, input logic [3:0] x, input logic [3:0] y);
      logic [3:0] r;
      case (op)
         0:  r = 4'd0;
         1:  r = 4'd1;
         2:  r = 4'hF;
         3:  r = x;
         4:  r = y;
         5:  r = ~x;
         6:  r = ~y;
         7:  r = 4'd0 - x;
         8:  r = 4'd0 - y;
         9:  r = x + 4'd1;
         10: r = y + 4'd1;
         11: r = x - 4'd1;
         12: r = y - 4'd1;
         13: r = x + y;
         14: r = x - y;
         15: r = y - x;
         16: r = x & y;
         default: r = x | y;
      endcase
      return r;
   endfunction

   assign ctl   = {zx, nx, zy, ny, fSel, no};
   assign ctl3  = {zx3, nx3, zy3, ny3, fSel3, no3};
   assign aluO  = aluEval(ctl, aluX, aluY);
   assign aluO3 = aluEval(ctl3, aluX3, aluY3);

   alu_driver #(.SETTLE_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady),
      .cmd_op_i(cmdOp), .cmd_x_i(cmdX), .cmd_y_i(cmdY),
      .alu_zx_o(zx), .alu_nx_o(nx), .alu_zy_o(zy), .alu_ny_o(ny),
      .alu_f_o(fSel), .alu_no_o(no), .alu_x_o(aluX), .alu_y_o(aluY),
      .alu_o_i(aluO),
      .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_data_o(rspData),
      .rsp_zr_o(rspZr), .rsp_ng_o(rspNg), .rsp_err_o(rspErr)
   );

   alu_driver #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst3_n),
      .cmd_valid_i(cmdValid3), .cmd_ready_o(cmdReady3),
      .cmd_op_i(cmdOp3), .cmd_x_i(cmdX3), .cmd_y_i(cmdY3),
      .alu_zx_o(zx3), .alu_nx_o(nx3), .alu_zy_o(zy3), .alu_ny_o(ny3),
      .alu_f_o(fSel3), .alu_no_o(no3), .alu_x_o(aluX3), .alu_y_o(aluY3),
      .alu_o_i(aluO3),
      .rsp_valid_o(rspValid3), .rsp_ready_i(rspReady3), .rsp_data_o(rspData3),
      .rsp_zr_o(rspZr3), .rsp_ng_o(rspNg3), .rsp_err_o(rspErr3)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   // Reference model for the settle-1 driver: a command is busy for one cycle, then its
   // response (computed from the op meaning) is shown until consumed.
   bit         mBusy = 1'b0;
   bit         mResp = 1'b0;
   int         mLeft = 0;
   logic [5:0] expCtl = '0;
   logic [3:0] expX = '0, expY = '0, expData = '0, pendData = '0;
   logic       expZr = 1'b0, expNg = 1'b0, expErr = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy = 1'b0; mResp = 1'b0; mLeft = 0;
         expCtl = '0; expX = '0; expY = '0;
         expData = '0; expZr = 1'b0; expNg = 1'b0; expErr = 1'b0;
      end else if (mResp) begin
         if (rspReady) mResp = 1'b0;
      end else if (mBusy) begin
         mLeft--;
         if (mLeft == 0) begin
            mBusy = 1'b0;
            mResp = 1'b1;
            expData = pendData;
            expZr = (pendData == 4'd0);
            expNg = pendData[3];
            expErr = 1'b0;
         end
      end else if (cmdValid) begin
         if (int'(cmdOp) <= 17) begin
            expCtl = ctlTable[cmdOp];
            expX = cmdX;
            expY = cmdY;
            pendData = opResult(int'(cmdOp), cmdX, cmdY);
            mBusy = 1'b1;
            mLeft = 1;
         end else begin
            expData = '0; expZr = 1'b0; expNg = 1'b0; expErr = 1'b1;
            mResp = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("cmd_ready", cmdReady, !(mBusy || mResp));
      checkOutput("rsp_valid", rspValid, mResp);
      checkOutput("alu_ctl", ctl, expCtl);
      checkOutput("alu_x", aluX, expX);
      checkOutput("alu_y", aluY, expY);
      checkOutput("rsp_data", rspData, expData);
      checkOutput("rsp_zr", rspZr, expZr);
      checkOutput("rsp_ng", rspNg, expNg);
      checkOutput("rsp_err", rspErr, expErr);
   end

   task automatic applyStimulus(input logic [4:0] op, input logic [3:0] x, input logic [3:0] y);
      cmdValid = 1'b1; cmdOp = op; cmdX = x; cmdY = y;
      @(posedge clk); #1;
      cmdValid = 1'b0;
   endtask

   task automatic waitRsp();
      int n = 0;
      while (!rspValid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rspValid) checkOutput("rsp_valid_timeout", rspValid, 1);
   endtask

   task automatic finishRsp();
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;
   endtask

   task automatic runOp(input logic [4:0] op, input logic [3:0] x, input logic [3:0] y);
      applyStimulus(op, x, y);
      waitRsp();
      finishRsp();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b1; rst3_n = 1'b1;
      cmdValid = 1'b0; cmdOp = '0; cmdX = '0; cmdY = '0; rspReady = 1'b0;
      cmdValid3 = 1'b0; cmdOp3 = '0; cmdX3 = '0; cmdY3 = '0; rspReady3 = 1'b0;
      #1;
      rst_n = 1'b0; rst3_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; rst3_n = 1'b1;
      checkOutput("reset_cmd_ready", cmdReady, 1);
      checkOutput("reset_rsp_valid", rspValid, 0);
      checkOutput("reset_ctl", ctl, 6'b000000);

      // x+y
      applyStimulus(5'd13, 4'd3, 4'd4);
      checkOutput("add_ctl", ctl, 6'b000010);
      checkOutput("add_alu_x", aluX, 4'd3);
      checkOutput("add_alu_y", aluY, 4'd4);
      checkOutput("add_not_yet_valid", rspValid, 0);
      @(posedge clk); #1;
      checkOutput("add_rsp_valid", rspValid, 1);
      checkOutput("add_rsp_data", rspData, 4'd7);
      checkOutput("add_rsp_zr", rspZr, 0);
      checkOutput("add_rsp_ng", rspNg, 0);
      checkOutput("add_rsp_err", rspErr, 0);
      finishRsp();
      checkOutput("add_cmd_ready_back", cmdReady, 1);

      // x-y negative, then zero
      applyStimulus(5'd14, 4'd2, 4'd5);
      @(posedge clk); #1;
      checkOutput("sub_rsp_data", rspData, 4'b1101);
      checkOutput("sub_rsp_ng", rspNg, 1);
      finishRsp();
      applyStimulus(5'd0, 4'd6, 4'd9);
      @(posedge clk); #1;
      checkOutput("zero_rsp_data", rspData, 4'd0);
      checkOutput("zero_rsp_zr", rspZr, 1);
      finishRsp();

      // Illegal op after x-y leaves controls in place
      runOp(5'd14, 4'd9, 4'd3);
      applyStimulus(5'd31, 4'd1, 4'd2);
      checkOutput("illegal_rsp_valid", rspValid, 1);
      checkOutput("illegal_rsp_err", rspErr, 1);
      checkOutput("illegal_rsp_data", rspData, 4'd0);
      checkOutput("illegal_ctl_kept", ctl, 6'b010011);
      checkOutput("illegal_alu_x_kept", aluX, 4'd9);

      // Back-pressure on the response while commands are offered
      for (int i = 0; i < 5; i++) begin
         cmdValid = (i % 2 == 0);
         cmdOp = 5'(i + 3);
         cmdX = 4'(i);
         cmdY = 4'(i + 8);
         @(posedge clk); #1;
         checkOutput("stall_rsp_valid", rspValid, 1);
         checkOutput("stall_cmd_ready", cmdReady, 0);
         checkOutput("stall_rsp_err", rspErr, 1);
         checkOutput("stall_ctl", ctl, 6'b010011);
      end
      cmdValid = 1'b0;
      finishRsp();
      checkOutput("stall_release_cmd_ready", cmdReady, 1);
      checkOutput("stall_release_rsp_valid", rspValid, 0);

      // Every legal op plus the first illegal code
      for (int op = 0; op < 18; op++)
         runOp(5'(op), 4'(op * 7 + 3), 4'(op * 5 + 1));
      runOp(5'd18, 4'd4, 4'd4);

      // Asynchronous reset mid-cycle while a response is pending
      applyStimulus(5'd17, 4'd5, 4'd10);
      @(posedge clk); #1;
      checkOutput("or_rsp_data", rspData, 4'd15);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_cmd_ready", cmdReady, 1);
      checkOutput("async_rsp_valid", rspValid, 0);
      checkOutput("async_ctl", ctl, 6'b000000);
      checkOutput("async_alu_x", aluX, 4'd0);
      checkOutput("async_alu_y", aluY, 4'd0);
      checkOutput("async_rsp_data", rspData, 4'd0);
      checkOutput("async_rsp_ng", rspNg, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Settle-3 driver: reset during DRIVE aborts, re-issue completes
      cmdValid3 = 1'b1; cmdOp3 = 5'd9; cmdX3 = 4'd15; cmdY3 = 4'd0;
      @(posedge clk); #1;
      cmdValid3 = 1'b0;
      checkOutput("s3_ctl", ctl3, 6'b011111);
      checkOutput("s3_alu_x", aluX3, 4'd15);
      @(posedge clk); #1;
      rst3_n = 1'b0;
      #2;
      checkOutput("s3_abort_rsp_valid", rspValid3, 0);
      checkOutput("s3_abort_cmd_ready", cmdReady3, 1);
      rst3_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("s3_idle_rsp_valid", rspValid3, 0);
         checkOutput("s3_idle_cmd_ready", cmdReady3, 1);
      end
      cmdValid3 = 1'b1;
      @(posedge clk); #1;
      cmdValid3 = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checkOutput("s3_settling_rsp_valid", rspValid3, 0);
      end
      @(posedge clk); #1;
      checkOutput("s3_rsp_valid", rspValid3, 1);
      checkOutput("s3_rsp_data", rspData3, 4'd0);
      checkOutput("s3_rsp_zr", rspZr3, 1);
      checkOutput("s3_rsp_ng", rspNg3, 0);
      checkOutput("s3_rsp_err", rspErr3, 0);
      rspReady3 = 1'b1;
      @(posedge clk); #1;
      rspReady3 = 1'b0;
      checkOutput("s3_cmd_ready_back", cmdReady3, 1);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequential initiator for the 4-bit zx/nx/zy/ny/f/no ALU. Accepts an encoded operation plus two operands over a valid/ready command channel, decodes the operation into the six ALU control bits, and drives the operands. After a programmable settle time it samples the ALU's four result bits and returns result, zero and negative flags over a valid/ready response channel. It sits between the sequencing logic (or board switches) and the ALU, so the ALU can be exercised one operation at a time.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU drive is held before sampling; legal range 1..15.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 5: operation code (see Operation).
- `cmd_x` in 4: operand x.
- `cmd_y` in 4: operand y.
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no` out 1 each: registered ALU controls.
- `alu_x` out 4: registered operand x to ALU.
- `alu_y` out 4: registered operand y to ALU.
- `alu_o` in 4: ALU result; bit 0 = o1 … bit 3 = o4.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_data` out 4: captured result.
- `rsp_zr` out 1: result == 0.
- `rsp_ng` out 1: result bit 3.
- `rsp_err` out 1: illegal op code.

## Operation
- Op codes, with control bits zx nx zy ny f no:
  - 0: 0 = 101010
  - 1: 1 = 111111
  - 2: -1 = 111010
  - 3: x = 001100
  - 4: y = 110000
  - 5: !x = 001101
  - 6: !y = 110001
  - 7: -x = 001111
  - 8: -y = 110011
  - 9: x+1 = 011111
  - 10: y+1 = 110111
  - 11: x-1 = 001110
  - 12: y-1 = 110010
  - 13: x+y = 000010
  - 14: x-y = 010011
  - 15: y-x = 000111
  - 16: x&y = 000000
  - 17: x|y = 010101
  - 18–31: illegal.
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`:
    - legal op: load controls, `alu_x`, `alu_y`; clear settle counter; go to DRIVE.
    - illegal op: leave ALU outputs unchanged; load `rsp_data`=0, `rsp_zr`=0, `rsp_ng`=0, `rsp_err`=1; go to RESP.
  - DRIVE: ALU outputs held constant; counter increments each cycle. On the cycle where counter == `SETTLE_CYCLES`-1: capture `alu_o` into `rsp_data`, set `rsp_zr` = (`alu_o`==0), `rsp_ng` = `alu_o`[3], `rsp_err`=0; go to RESP.
  - RESP: `rsp_valid`=1; all `rsp_*` stable. On `rsp_ready` go to IDLE.
- ALU outputs keep their last values in IDLE and RESP; they are never cleared between operations.
- All arithmetic is 4-bit two's complement, performed in the ALU; the driver does no arithmetic beyond the zero test.

## Timing
- Reset (async assert, any state):
  - state IDLE; `cmd_ready`=1.
  - all `alu_*` outputs 0 (controls 000000, x=y=0).
  - `rsp_valid`=0, `rsp_data`=0, `rsp_zr`=0, `rsp_ng`=0, `rsp_err`=0.
- Reset mid-DRIVE or mid-RESP aborts the operation; no response is produced.
- Latency, legal op accepted at edge E0:
  - ALU outputs change after E0.
  - `alu_o` is sampled at edge E0+`SETTLE_CYCLES`.
  - `rsp_valid` is high after that same edge.
- Latency, illegal op: `rsp_valid` high after E0.
- Response handshake completes at an edge with `rsp_valid`&&`rsp_ready`. `cmd_ready` rises after that edge; there is no same-cycle turnaround.
- Minimum period per legal op: `SETTLE_CYCLES`+2 cycles.
- `cmd_valid` outside IDLE is ignored; command inputs are sampled only at the accepting edge.

## Structure
- Package `alu_pkg`:
  - op-code localparams (OP_ZERO … OP_OR).
  - 6-bit control constants.
  - FSM state enum {IDLE, DRIVE, RESP}.
- Sub-module `alu_op_decode`: purely combinational; `cmd_op` → 6 control bits plus `legal`.
- Top holds the FSM, 4-bit settle counter and output registers.

## Test plan
Bench pairs the driver with a behavioural ALU model, `SETTLE_CYCLES`=1 unless stated.
1. Assert `rst_n`=0 mid-cycle → immediately all outputs 0, `cmd_ready`=1, `rsp_valid`=0.
2. op 13, x=3, y=4 → controls 000010, `alu_x`=3, `alu_y`=4; one cycle later `rsp_valid`=1, `rsp_data`=7, zr=0, ng=0, err=0.
3. op 14, x=2, y=5 → `rsp_data`=4'b1101, ng=1. Then op 0 → `rsp_data`=0, zr=1.
4. op 31 with prior controls 010011 → `rsp_valid` the cycle after accept, err=1, `rsp_data`=0; controls still 010011.
5. Hold `rsp_ready`=0 for 5 cycles while toggling `cmd_valid` and inputs → `rsp_*` stable, `cmd_ready`=0, no new command taken. Raise `rsp_ready` → `cmd_ready`=1 next cycle.
6. `SETTLE_CYCLES`=3, op 9, x=15; pulse `rst_n` low in the second DRIVE cycle → no `rsp_valid`, FSM back in IDLE. Re-issue the same op → `rsp_data`=0, zr=1, 3 cycles after accept.
